// File: rtl/interrupt_sampler_sync_chain.sv
// sync_chain: optional input synchronizer for the interrupt sampler.
// Delays the input d by DEPTH flops clocked on clk. DEPTH = 0 gives a
// combinational pass-through. The flops are cleared while rst is high.
// Ports:
//   clk - sampling clock
//   rst - synchronous active-high clear of the synchronizer flops
//   d   - raw (possibly asynchronous) input
//   q   - synchronized output
module sync_chain #(
    parameter int DEPTH = 0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    generate
        if (DEPTH == 0) begin : g_pass
            // clk and rst have no load in the pass-through case.
            logic unused_clk_rst;
            assign unused_clk_rst = clk ^ rst;
            assign q = d;
        end else begin : g_sync
            logic [DEPTH-1:0] stages = '0;

            always_ff @(posedge clk) begin
                if (rst) begin
                    stages <= '0;
                end else begin
                    stages[0] <= d;
                    for (int i = 1; i < DEPTH; i++) begin
                        stages[i] <= stages[i-1];
                    end
                end
            end

            assign q = stages[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/interrupt_sampler.sv
// interrupt_sampler: captures an interrupt event into a sticky flag.
// The source is optionally synchronized, then either its rising edge
// (EDGE_MODE = 1) or its high level (EDGE_MODE = 0) sets indication.
// indication stays set until rst; rst always wins over a capture.
// Ports:
//   clk        - single clock, all state changes on its rising edge
//   rst        - synchronous active-high clear of indication and synchronizer
//   intr       - interrupt source; named intr because "int" is a reserved
//                word in SystemVerilog
//   indication - sticky captured-interrupt flag, straight from a flop
module interrupt_sampler #(
    parameter int SYNC_STAGES = 0,
    parameter bit EDGE_MODE   = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic intr,
    output logic indication
);

    logic int_s;
    logic prev  = 1'b0;
    logic ind_q = 1'b0;
    logic trigger;

    sync_chain #(
        .DEPTH(SYNC_STAGES)
    ) u_sync (
        .clk(clk),
        .rst(rst),
        .d  (intr),
        .q  (int_s)
    );

    // prev keeps tracking int_s through reset, so a level held high across
    // reset deassertion is not seen as a fresh edge.
    always_ff @(posedge clk) begin
        prev <= int_s;
    end

    always_comb begin
        trigger = 1'b0;
        if (EDGE_MODE) begin
            trigger = int_s & ~prev;
        end else begin
            trigger = int_s;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ind_q <= 1'b0;
        end else if (trigger) begin
            ind_q <= 1'b1;
        end
    end

    assign indication = ind_q;

endmodule

// File: tb/tb_interrupt_sampler.sv
module tb_interrupt_sampler;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic intr = 1'b0;
    logic ind_e0, ind_l0, ind_e2, ind_l2;

    always #3 clk = ~clk;

    interrupt_sampler #(.SYNC_STAGES(0), .EDGE_MODE(1'b1)) dut_e0 (
        .clk(clk), .rst(rst), .intr(intr), .indication(ind_e0));
    interrupt_sampler #(.SYNC_STAGES(0), .EDGE_MODE(1'b0)) dut_l0 (
        .clk(clk), .rst(rst), .intr(intr), .indication(ind_l0));
    interrupt_sampler #(.SYNC_STAGES(2), .EDGE_MODE(1'b1)) dut_e2 (
        .clk(clk), .rst(rst), .intr(intr), .indication(ind_e2));
    interrupt_sampler #(.SYNC_STAGES(2), .EDGE_MODE(1'b0)) dut_l2 (
        .clk(clk), .rst(rst), .intr(intr), .indication(ind_l2));

    // Table row: inputs for one edge and expected indication after it for
    // the two unsynchronized instances (edge mode, level mode).
    typedef struct packed {
        logic rst;
        logic intr;
        logic exp_e;
        logic exp_l;
    } vec_t;

    typedef struct {
        logic [3:0] exp;
        logic [3:0] mask;
        string      tag;
        int         idx;
    } sb_t;

    vec_t  vecs[29];
    sb_t   sbq[$];
    string names[4] = '{"edge_s0", "level_s0", "edge_s2", "level_s2"};
    int    checks = 0;
    int    errors = 0;

    task automatic check_one();
        sb_t        e;
        logic [3:0] got;
        if (sbq.size() == 0) begin
            errors++;
            $display("FAIL scoreboard_empty got 0 entries expected 1");
            return;
        end
        e   = sbq.pop_front();
        got = {ind_l2, ind_e2, ind_l0, ind_e0};
        for (int b = 0; b < 4; b++) begin
            if (e.mask[b]) begin
                checks++;
                if (got[b] !== e.exp[b]) begin
                    errors++;
                    $display("FAIL %s step %0d %s indication got %b expected %b",
                             e.tag, e.idx, names[b], got[b], e.exp[b]);
                end
            end
        end
    endtask

    // Drive inputs away from the active edge, queue the expectation, then
    // sample 1 ns after the edge that consumes them.
    task automatic step(input logic r, input logic i, input logic [3:0] exp,
                        input logic [3:0] mask, input string tag, input int idx);
        sb_t e;
        @(negedge clk);
        rst  = r;
        intr = i;
        e.exp  = exp;
        e.mask = mask;
        e.tag  = tag;
        e.idx  = idx;
        sbq.push_back(e);
        @(posedge clk);
        #1;
        check_one();
    endtask

    initial begin
        // reset
        vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{1'b1, 1'b0, 1'b0, 1'b0};
        // single shot
        vecs[2]  = '{1'b0, 1'b0, 1'b0, 1'b0};
        vecs[3]  = '{1'b0, 1'b1, 1'b1, 1'b1};
        vecs[4]  = '{1'b0, 1'b0, 1'b1, 1'b1};
        vecs[5]  = '{1'b0, 1'b0, 1'b1, 1'b1};
        // clear
        vecs[6]  = '{1'b1, 1'b0, 1'b0, 1'b0};
        vecs[7]  = '{1'b0, 1'b0, 1'b0, 1'b0};
        vecs[8]  = '{1'b0, 1'b0, 1'b0, 1'b0};
        // overlapped pulses
        vecs[9]  = '{1'b0, 1'b1, 1'b1, 1'b1};
        vecs[10] = '{1'b0, 1'b0, 1'b1, 1'b1};
        vecs[11] = '{1'b0, 1'b1, 1'b1, 1'b1};
        vecs[12] = '{1'b0, 1'b0, 1'b1, 1'b1};
        // pulse while clearing; rst and int fall together
        vecs[13] = '{1'b1, 1'b0, 1'b0, 1'b0};
        vecs[14] = '{1'b1, 1'b1, 1'b0, 1'b0};
        vecs[15] = '{1'b0, 1'b0, 1'b0, 1'b0};
        vecs[16] = '{1'b0, 1'b0, 1'b0, 1'b0};
        // double pulse, then clear
        vecs[17] = '{1'b0, 1'b1, 1'b1, 1'b1};
        vecs[18] = '{1'b0, 1'b0, 1'b1, 1'b1};
        vecs[19] = '{1'b0, 1'b1, 1'b1, 1'b1};
        vecs[20] = '{1'b0, 1'b0, 1'b1, 1'b1};
        vecs[21] = '{1'b1, 1'b0, 1'b0, 1'b0};
        // held level across reset deassertion, then a fresh edge
        vecs[22] = '{1'b1, 1'b1, 1'b0, 1'b0};
        vecs[23] = '{1'b1, 1'b1, 1'b0, 1'b0};
        vecs[24] = '{1'b0, 1'b1, 1'b0, 1'b1};
        vecs[25] = '{1'b0, 1'b1, 1'b0, 1'b1};
        vecs[26] = '{1'b0, 1'b0, 1'b0, 1'b1};
        vecs[27] = '{1'b0, 1'b1, 1'b1, 1'b1};
        vecs[28] = '{1'b1, 1'b0, 1'b0, 1'b0};

        for (int k = 0; k < 29; k++) begin
            step(vecs[k].rst, vecs[k].intr, {2'b00, vecs[k].exp_l, vecs[k].exp_e},
                 4'b0011, "table", k);
        end

        // Two-stage synchronizer, level held across reset. The synchronizer
        // is cleared in reset, so the held level reaches int_s two edges after
        // release and looks like a fresh edge in both modes.
        // Expected bits: {level_s2, edge_s2, level_s0, edge_s0}.
        step(1'b1, 1'b1, 4'b0000, 4'b1111, "s2_held", 0);
        step(1'b1, 1'b1, 4'b0000, 4'b1111, "s2_held", 1);
        step(1'b1, 1'b1, 4'b0000, 4'b1111, "s2_held", 2);
        step(1'b0, 1'b1, 4'b0010, 4'b1111, "s2_held", 3);
        step(1'b0, 1'b1, 4'b0010, 4'b1111, "s2_held", 4);
        step(1'b0, 1'b1, 4'b1110, 4'b1111, "s2_held", 5);
        step(1'b0, 1'b0, 4'b1110, 4'b1111, "s2_held", 6);

        // Two-stage synchronizer, single one-cycle pulse: +2 cycles latency.
        step(1'b1, 1'b0, 4'b0000, 4'b1111, "s2_pulse", 0);
        step(1'b1, 1'b0, 4'b0000, 4'b1111, "s2_pulse", 1);
        step(1'b1, 1'b0, 4'b0000, 4'b1111, "s2_pulse", 2);
        step(1'b0, 1'b1, 4'b0011, 4'b1111, "s2_pulse", 3);
        step(1'b0, 1'b0, 4'b0011, 4'b1111, "s2_pulse", 4);
        step(1'b0, 1'b0, 4'b1111, 4'b1111, "s2_pulse", 5);
        step(1'b0, 1'b0, 4'b1111, 4'b1111, "s2_pulse", 6);
        step(1'b1, 1'b0, 4'b0000, 4'b1111, "s2_pulse", 7);

        if (sbq.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_leftover got %0d entries expected 0", sbq.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/interrupt_sampler.md
INTERRUPT_SAMPLER -- requirements
Module: interrupt_sampler

Interface
REQ-001 Parameter SYNC_STAGES, default 0, meaning number of input synchronizer flops on int; legal values 0..3.
REQ-002 Parameter EDGE_MODE, default 1, meaning 1 = trigger on a sampled rising edge of int, 0 = trigger on a sampled high level.
REQ-003 Port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 Port rst  input  1  reset, synchronous, active-high; it also clears a pending indication.
REQ-005 Port int  input  1  interrupt source; may be asynchronous when SYNC_STAGES > 0.
REQ-006 Port indication  output  1  sticky flag meaning an interrupt has been captured since the last rst; driven directly by a register.

Function
REQ-007 int_s SHALL be int delayed through SYNC_STAGES flops; with SYNC_STAGES = 0, int_s SHALL be int itself (combinational).
REQ-008 prev SHALL be a register that loads int_s on every clk edge, including while rst is high.
REQ-009 trigger SHALL be int_s AND NOT prev when EDGE_MODE = 1, and int_s when EDGE_MODE = 0.
REQ-010 On a clk edge with rst = 1, indication SHALL become 0 regardless of trigger (clear wins over capture).
REQ-011 On a clk edge with rst = 0 and trigger = 1, indication SHALL become 1.
REQ-012 On a clk edge with rst = 0 and trigger = 0, indication SHALL hold its value.
REQ-013 Latency (SYNC_STAGES = 0): int high at edge N (rising in EDGE_MODE 1) SHALL make indication 1 immediately after edge N; each synchronizer stage adds one cycle.
REQ-014 A pulse on int at least one clock period wide, spanning one rising clk edge, SHALL always be captured.
REQ-015 Further triggers while indication = 1 SHALL leave indication at 1; no count is kept.
REQ-016 EDGE_MODE 1: an int level held high across rst deassertion SHALL NOT re-set indication; only a new 0->1 transition SHALL.
REQ-017 EDGE_MODE 0: an int level still high on the first edge after rst deasserts SHALL set indication on that edge.
REQ-018 When rst and int fall on the same edge, the trigger SHALL be discarded and indication SHALL remain 0.

Reset
REQ-019 While rst = 1, indication SHALL be 0 and the synchronizer flops SHALL be 0.
REQ-020 prev SHALL follow int_s during reset, per REQ-008.
REQ-021 The power-up value of every register SHALL be 0, for simulation.
REQ-022 There SHALL be no asynchronous reset path.

Structure
REQ-023 No shared package SHALL be required; the parameters SHALL be local to the module.
REQ-024 The synchronizer SHALL be a natural sub-module, sync_chain, parameterized by depth; depth 0 SHALL be a pass-through.
REQ-025 Edge detection, the sticky flag and the clear logic SHALL reside in interrupt_sampler.

Verification (SYNC_STAGES = 0, EDGE_MODE = 1, clock period 6 ns)
REQ-026 Single shot: rst pulse, then int = 1 for one cycle -> indication 0 -> 1 after the pulse edge and stays 1 until rst.
REQ-027 Clear: rst = 1 for one cycle while indication = 1 -> indication 0 after that edge and stays 0 with int = 0.
REQ-028 Overlapped: set indication, pulse int again without rst -> indication stays 1 and does not glitch.
REQ-029 Pulse while clearing: rst = 1, int pulses for one cycle, then rst and int fall on the same edge -> indication stays 0 throughout.
REQ-030 Double pulse: after a clear, two one-cycle int pulses 6 ns apart -> indication rises on the first pulse and stays 1; a following rst gives 0.
REQ-031 Held level: int high across rst deassertion -> indication 0 (EDGE_MODE 1) or 1 on the first post-reset edge (EDGE_MODE 0); repeat with SYNC_STAGES = 2 to check +2 cycles of latency.
